// File: rtl/qe_m_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qe_m_pkg
//  Description : Shared widths and mode encodings for the qe_m arithmetic
//                unit (quadratic evaluator / multiply-accumulate).
//  Contents    : DATA_W   - operand width
//                RES_W    - result / accumulator width
//                MODE_QE  - mode value selecting a*x^2 + b*x + c
//                MODE_MAC - mode value selecting accumulate of a*x
//  Revision    : 1.0 - initial release
// ============================================================================
package qe_m_pkg;

    localparam int   DATA_W   = 8;
    localparam int   RES_W    = 16;

    localparam logic MODE_QE  = 1'b0;
    localparam logic MODE_MAC = 1'b1;

endpackage : qe_m_pkg
`default_nettype wire

// File: rtl/qe_m_stage1.sv
`default_nettype none
// ============================================================================
//  Module      : qe_m_stage1
//  Description : First pipeline stage of qe_m. Registers the full-width
//                products x^2, a*x and b*x together with the operands still
//                needed downstream (a, c) and the sideband (mode, last, valid).
//  Ports       : clk, reset          - clock, async active-high reset
//                i_a, i_b, i_c, i_x  - 8-bit unsigned operands
//                i_mode, i_valid,
//                i_last              - sample sideband
//                o_x_sq, o_ax, o_bx  - registered 16-bit products
//                o_a, o_c            - registered operands
//                o_mode, o_last,
//                o_valid             - registered sideband
//  Revision    : 1.0 - initial release
// ============================================================================
module qe_m_stage1
    import qe_m_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_x,
    input  logic              i_mode,
    input  logic              i_valid,
    input  logic              i_last,
    output logic [RES_W-1:0]  o_x_sq,
    output logic [RES_W-1:0]  o_ax,
    output logic [RES_W-1:0]  o_bx,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_c,
    output logic              o_mode,
    output logic              o_last,
    output logic              o_valid
);

    // 8x8 products are exact in 16 bits.
    logic [RES_W-1:0] w_x_sq;
    logic [RES_W-1:0] w_ax;
    logic [RES_W-1:0] w_bx;

    assign w_x_sq = {8'd0, i_x} * {8'd0, i_x};
    assign w_ax   = {8'd0, i_a} * {8'd0, i_x};
    assign w_bx   = {8'd0, i_b} * {8'd0, i_x};

    // Data registers only load on a valid sample; the valid bit always
    // follows the input so a dropped sample cannot reach stage 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_x_sq  <= '0;
            o_ax    <= '0;
            o_bx    <= '0;
            o_a     <= '0;
            o_c     <= '0;
            o_mode  <= MODE_QE;
            o_last  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_x_sq <= w_x_sq;
                o_ax   <= w_ax;
                o_bx   <= w_bx;
                o_a    <= i_a;
                o_c    <= i_c;
                o_mode <= i_mode;
                o_last <= i_last;
            end
        end
    end

endmodule : qe_m_stage1
`default_nettype wire

// File: rtl/qe_m.sv
`default_nettype none
// ============================================================================
//  Module      : qe_m
//  Description : Dual-mode 8-bit arithmetic unit, two-stage pipeline.
//                mode 0: result = a*x^2 + b*x + c (mod 2^16) per sample.
//                mode 1: accumulates a*x; the sample flagged last emits
//                        acc + a*x and clears the accumulator.
//                Latency 2 cycles, one sample per cycle, no back-pressure.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset
//                in_a..in_x - 8-bit unsigned operands
//                mode       - 0 quadratic, 1 MAC
//                valid_in   - operands form a sample this edge
//                last_input - final MAC term
//                valid_out  - one-cycle strobe, result is new
//                result     - 16-bit unsigned result, held between strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module qe_m
    import qe_m_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_x,
    input  logic              mode,
    input  logic              valid_in,
    input  logic              last_input,
    output logic              valid_out,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0]  w_s1_x_sq;
    logic [RES_W-1:0]  w_s1_ax;
    logic [RES_W-1:0]  w_s1_bx;
    logic [DATA_W-1:0] w_s1_a;
    logic [DATA_W-1:0] w_s1_c;
    logic              w_s1_mode;
    logic              w_s1_last;
    logic              w_s1_valid;

    qe_m_stage1 u_stage1 (
        .clk     (clk),
        .reset   (reset),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_c     (in_c),
        .i_x     (in_x),
        .i_mode  (mode),
        .i_valid (valid_in),
        .i_last  (last_input),
        .o_x_sq  (w_s1_x_sq),
        .o_ax    (w_s1_ax),
        .o_bx    (w_s1_bx),
        .o_a     (w_s1_a),
        .o_c     (w_s1_c),
        .o_mode  (w_s1_mode),
        .o_last  (w_s1_last),
        .o_valid (w_s1_valid)
    );

    // ------------------------------------------------------------------
    // Stage 2: sum / accumulate
    // ------------------------------------------------------------------
    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] w_ax2_lo;
    logic [RES_W-1:0] w_quad;
    logic [RES_W-1:0] w_mac_sum;

    // a*x^2 is a 24-bit product, but the final sum is taken mod 2^16 and
    // carries only move upward, so its low 16 bits are all that matter.
    assign w_ax2_lo  = {8'd0, w_s1_a} * w_s1_x_sq;
    assign w_quad    = w_ax2_lo + w_s1_bx + {8'd0, w_s1_c};
    assign w_mac_sum = r_acc + w_s1_ax;

    // The accumulator feeds back within this stage, so back-to-back MAC
    // terms see the previous term's contribution without a hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            result    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (w_s1_valid) begin
                if (w_s1_mode == MODE_QE) begin
                    result    <= w_quad;
                    valid_out <= 1'b1;
                end else if (w_s1_last) begin
                    result    <= w_mac_sum;
                    valid_out <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc     <= w_mac_sum;
                end
            end
        end
    end

endmodule : qe_m
`default_nettype wire

// File: tb/tb_qe_m.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qe_m
//  Description : Self-checking bench for qe_m. A reference model computes
//                each expected result when the sample is driven and queues
//                it with the cycle on which it must appear; every cycle the
//                valid strobe and held result are compared to the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qe_m;

    logic        clk;
    logic        reset;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  in_c;
    logic [7:0]  in_x;
    logic        mode;
    logic        valid_in;
    logic        last_input;
    logic        valid_out;
    logic [15:0] result;

    qe_m dut (
        .clk        (clk),
        .reset      (reset),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_x       (in_x),
        .mode       (mode),
        .valid_in   (valid_in),
        .last_input (last_input),
        .valid_out  (valid_out),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [15:0] acc_m;
    logic [15:0] exp_result;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock and compare outputs #1 after the edge.
    task automatic tick();
        logic exp_vo;
        @(posedge clk);
        cyc++;
        #1;
        exp_vo = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        check_bit("valid_out", valid_out, exp_vo);
        if (exp_vo) begin
            exp_result = sb_q[0].val;
            void'(sb_q.pop_front());
        end
        check_word("result", {16'd0, result}, {16'd0, exp_result});
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] x,
                         input logic m, input logic v, input logic l);
        logic [31:0] t;
        exp_t        e;
        in_a = a; in_b = b; in_c = c; in_x = x;
        mode = m; valid_in = v; last_input = l;
        if (v) begin
            if (m == 1'b0) begin
                t = 32'(a) * 32'(x) * 32'(x) + 32'(b) * 32'(x) + 32'(c);
                e.due = cyc + 2;
                e.val = t[15:0];
                sb_q.push_back(e);
            end else begin
                t = 32'(acc_m) + 32'(a) * 32'(x);
                if (l) begin
                    e.due = cyc + 2;
                    e.val = t[15:0];
                    sb_q.push_back(e);
                    acc_m = 16'd0;
                end else begin
                    acc_m = t[15:0];
                end
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Reset asserted between edges; in-flight work and partial sums vanish.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check_bit("rst_valid_out", valid_out, 1'b0);
        check_word("rst_result", {16'd0, result}, 32'd0);
        sb_q.delete();
        acc_m      = 16'd0;
        exp_result = 16'd0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        acc_m      = 16'd0;
        exp_result = 16'd0;
        reset      = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_x = '0;
        mode = 1'b0; valid_in = 1'b0; last_input = 1'b0;

        // Reset state
        #1;
        check_bit("init_valid_out", valid_out, 1'b0);
        check_word("init_result", {16'd0, result}, 32'd0);
        tick();
        reset = 1'b0;
        idle(1);

        // Quadratic single sample, then an invalid sample that must be ignored
        drive(8'd100, 8'd5, 8'd25, 8'd8, 1'b0, 1'b1, 1'b0);
        drive(8'd4, 8'd7, 8'd11, 8'd1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_word("quad_single", {16'd0, exp_result}, 32'd6465);

        // Streaming quadratic, two consecutive valid samples
        drive(8'd100, 8'd5, 8'd3, 8'd9, 1'b0, 1'b1, 1'b0);
        drive(8'd100, 8'd5, 8'd3, 8'd9, 1'b0, 1'b1, 1'b0);
        idle(3);

        // MAC with an invalid gap term; last term carries last_input
        drive(8'd100, 8'd9, 8'd9, 8'd8, 1'b1, 1'b1, 1'b0);
        drive(8'd20, 8'd0, 8'd0, 8'd3, 1'b1, 1'b0, 1'b1);
        drive(8'd1, 8'd0, 8'd0, 8'd2, 1'b1, 1'b1, 1'b1);
        idle(2);
        drive(8'd2, 8'd0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Accumulator survives an interleaved quadratic sample
        drive(8'd3, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0);
        drive(8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 1'b1, 1'b1);
        drive(8'd5, 8'd0, 8'd0, 8'd6, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Back-to-back MAC terms
        drive(8'd10, 8'd0, 8'd0, 8'd10, 1'b1, 1'b1, 1'b0);
        drive(8'd20, 8'd0, 8'd0, 8'd20, 1'b1, 1'b1, 1'b0);
        drive(8'd30, 8'd0, 8'd0, 8'd30, 1'b1, 1'b1, 1'b1);
        idle(3);

        // MAC wrap-around and quadratic overflow
        drive(8'd255, 8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 1'b0);
        drive(8'd255, 8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 1'b1);
        drive(8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
        idle(3);
        check_word("quad_overflow", {16'd0, exp_result}, 32'd511);

        // Reset mid-MAC with a quadratic sample also in flight
        drive(8'd100, 8'd0, 8'd0, 8'd8, 1'b1, 1'b1, 1'b0);
        drive(8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 1'b1, 1'b0);
        pulse_reset();
        idle(2);
        drive(8'd1, 8'd0, 8'd0, 8'd2, 1'b1, 1'b1, 1'b1);
        idle(3);
        check_word("reset_mac", {16'd0, exp_result}, 32'd2);

        // Everything queued must have been delivered
        idle(2);
        check_word("drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_qe_m
`default_nettype wire
